// File: rtl/wall_follower_ctrl_if.sv
// Sensor/actuator bundle between the pipe robot front end and its controller.
// The environment (sensor side) is master; the controller is slave.
interface wall_follower_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             head;
    logic             left;
    logic             under;
    logic             barrier;
    logic             front;
    logic             turn;
    logic             remove;
    logic             stuck;
    logic [CNT_W-1:0] move_count;
    logic [CNT_W-1:0] trash_count;

    modport master (
        output head, left, under, barrier,
        input  front, turn, remove, stuck,
        input  move_count, trash_count
    );

    modport slave (
        input  head, left, under, barrier,
        output front, turn, remove, stuck,
        output move_count, trash_count
    );
endinterface

// File: rtl/wall_follower_ctrl.sv
// Left-hand wall-following pipe robot controller with barrier removal.
// Optional stuck watchdog enabled by defining ROBOT_STUCK_WATCHDOG_EN.
module wall_follower_ctrl #(
    parameter int REMOVE_CYCLES = 3,
    parameter int STUCK_LIMIT   = 8,
    parameter int CNT_W         = 16
) (
    input  logic                clock,
    input  logic                reset,
    wall_follower_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        SEEK,
        FOLLOW,
        LTURN,
        ROTATE,
        REMOVE,
        STUCK
    } state_t;

    localparam int RW =
        (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam logic [RW-1:0] REM_LAST = RW'(REMOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (REMOVE_CYCLES < 1 || STUCK_LIMIT < 4 || CNT_W < 2)
    begin : g_bad_param
        $error("wall_follower_ctrl: illegal parameter value");
    end

    state_t           state;
    state_t           state_d;
    logic [RW-1:0]    rem_cnt;
    logic [RW-1:0]    rem_cnt_d;
    logic [1:0]       rot_cnt;
    logic [1:0]       rot_cnt_d;
    logic             prev_front;
    logic [CNT_W-1:0] move_q;
    logic [CNT_W-1:0] trash_q;

    logic             act_f;
    logic             act_t;
    logic             act_r;
    logic             rem_last;
    logic             rem_done;
    logic             under_hit;
    logic [1:0]       trash_inc;
    logic [CNT_W:0]   trash_sum;
    logic             sensing;

    // rem_cnt stays 0 outside REMOVE, so the detect cycle is cycle 1
    assign rem_last = (rem_cnt == REM_LAST);
    assign sensing  = (state == SEEK) || (state == FOLLOW) ||
                      (state == LTURN);

`ifdef ROBOT_STUCK_WATCHDOG_EN
    localparam int WW = $clog2(STUCK_LIMIT + 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_trip;

    assign wd_trip = !act_f && !act_r && (state != STUCK) &&
                     (wd_cnt == WW'(STUCK_LIMIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (act_f) begin
            wd_cnt <= '0;
        end else if (!act_r && state != STUCK) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign bus.stuck = (state == STUCK);
`else
    assign bus.stuck = 1'b0;
`endif

    always_comb begin
        act_f     = 1'b0;
        act_t     = 1'b0;
        act_r     = 1'b0;
        state_d   = state;
        rot_cnt_d = rot_cnt;
        rem_cnt_d = '0;

        if (sensing && bus.barrier) begin
            act_r = 1'b1;
        end else begin
            unique case (state)
                SEEK: begin
                    act_f = !bus.head;
                    act_t = bus.head;
                    if (bus.left) state_d = FOLLOW;
                end
                FOLLOW: begin
                    unique case (1'b1)
                        !bus.left: begin
                            act_t   = 1'b1;
                            state_d = LTURN;
                        end
                        bus.left && !bus.head: begin
                            act_f = 1'b1;
                        end
                        bus.left && bus.head: begin
                            act_t     = 1'b1;
                            state_d   = ROTATE;
                            rot_cnt_d = 2'd2;
                        end
                    endcase
                end
                LTURN: begin
                    act_f = !bus.head;
                    act_t = bus.head;
                    if (!bus.head) state_d = FOLLOW;
                end
                ROTATE: begin
                    act_t     = 1'b1;
                    rot_cnt_d = rot_cnt - 1'b1;
                    if (rot_cnt == 2'd1) state_d = FOLLOW;
                end
                REMOVE: begin
                    act_r = 1'b1;
                end
                default: begin
                end
            endcase
        end

        if (act_r) begin
            if (rem_last) begin
                state_d = bus.left ? FOLLOW : SEEK;
            end else begin
                state_d   = REMOVE;
                rem_cnt_d = rem_cnt + 1'b1;
            end
        end

`ifdef ROBOT_STUCK_WATCHDOG_EN
        if (wd_trip) state_d = STUCK;
`endif
    end

    assign rem_done  = act_r && rem_last;
    assign under_hit = bus.under && prev_front;
    assign trash_inc = {1'b0, rem_done} + {1'b0, under_hit};
    assign trash_sum = {1'b0, trash_q} +
                       {{(CNT_W-1){1'b0}}, trash_inc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SEEK;
            rem_cnt    <= '0;
            rot_cnt    <= '0;
            prev_front <= 1'b0;
            move_q     <= '0;
            trash_q    <= '0;
        end else begin
            state      <= state_d;
            rem_cnt    <= rem_cnt_d;
            rot_cnt    <= rot_cnt_d;
            prev_front <= act_f;
            if (act_f && move_q != CNT_MAX) begin
                move_q <= move_q + 1'b1;
            end
            trash_q <= trash_sum[CNT_W] ? CNT_MAX
                                        : trash_sum[CNT_W-1:0];
        end
    end

    // actions are suppressed for the whole time reset is high
    assign bus.front       = act_f && !reset;
    assign bus.turn        = act_t && !reset;
    assign bus.remove      = act_r && !reset;
    assign bus.move_count  = move_q;
    assign bus.trash_count = trash_q;

endmodule
